// File: rtl/mccu.sv
// mccu: multi-cycle control unit for the 16-instruction, 12-bit-opcode ISA.
// Sequences IF/ID/EX/MEM/WB over a shared datapath. Memory accesses have a
// ready-handshake watchdog. A sticky TRAP state holds illegal-opcode and bus
// timeout faults. A wrapping counter tracks retired instructions.
module mccu #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32,
    parameter bit          TRAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      op,
    input  logic             z,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pcsource,
    output logic             reg_we,
    output logic             m2reg,
    output logic             sst,
    output logic             shift,
    output logic             aluimm,
    output logic             sext,
    output logic [3:0]       aluc,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);

    // The watchdog counter only has to reach TIMEOUT-1.
    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    state_t              cur;
    state_t              nxt;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                dec_legal;
    logic [3:0]          dec_aluc;
    logic                is_jump, is_beq, is_bne, is_load, is_store;

    logic                req_c, we_c, iord_c, irwe_c, pcwe_c, regwe_c, m2r_c, lvl_en;
    logic [1:0]          pcs_c;
    logic                retire, trap_ill, trap_bus;

    // Opcode decode: aluc is the instruction index; unknown encodings are illegal.
    always_comb begin
        dec_legal = 1'b1;
        dec_aluc  = 4'd0;
        case (op[11:6])
            6'b000000: begin
                if (op[5:0] != 6'b000001) dec_legal = 1'b0;
            end
            6'b000001: begin
                case (op[5:0])
                    6'b000001: dec_aluc = 4'd1;
                    6'b000010: dec_aluc = 4'd2;
                    6'b000100: dec_aluc = 4'd3;
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b000010: begin
                case (op[5:0])
                    6'b000001: dec_aluc = 4'd4;
                    6'b000010: dec_aluc = 4'd5;
                    6'b000011: dec_aluc = 4'd6;
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b000101: dec_aluc = 4'd7;
            6'b001001: dec_aluc = 4'd8;
            6'b001010: dec_aluc = 4'd9;
            6'b001100: dec_aluc = 4'd10;
            6'b001101: dec_aluc = 4'd11;
            6'b001110: dec_aluc = 4'd12;
            6'b001111: dec_aluc = 4'd13;
            6'b010000: dec_aluc = 4'd14;
            6'b010010: dec_aluc = 4'd15;
            default:   dec_legal = 1'b0;
        endcase
    end

    assign is_jump  = dec_legal && (dec_aluc == 4'd15);
    assign is_beq   = dec_legal && (dec_aluc == 4'd13);
    assign is_bne   = dec_legal && (dec_aluc == 4'd14);
    assign is_load  = dec_legal && (dec_aluc == 4'd11);
    assign is_store = dec_legal && (dec_aluc == 4'd12);

    // Next-state, strobe and event logic for the current state.
    always_comb begin
        nxt      = cur;
        req_c    = 1'b0;
        we_c     = 1'b0;
        iord_c   = 1'b0;
        irwe_c   = 1'b0;
        pcwe_c   = 1'b0;
        pcs_c    = 2'b00;
        regwe_c  = 1'b0;
        m2r_c    = 1'b0;
        lvl_en   = 1'b0;
        retire   = 1'b0;
        trap_ill = 1'b0;
        trap_bus = 1'b0;
        case (cur)
            S_IF: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    irwe_c = 1'b1;
                    pcwe_c = 1'b1;
                    nxt    = S_ID;
                end else if (wait_cnt == WAIT_LAST) begin
                    trap_bus = 1'b1;
                    nxt      = S_TRAP;
                end
            end
            S_ID: begin
                lvl_en = 1'b1;
                if (is_jump) begin
                    pcwe_c = 1'b1;
                    pcs_c  = 2'b11;
                    retire = 1'b1;
                    nxt    = S_IF;
                end else if (!dec_legal) begin
                    if (TRAP_EN) begin
                        trap_ill = 1'b1;
                        nxt      = S_TRAP;
                    end else begin
                        retire = 1'b1;
                        nxt    = S_IF;
                    end
                end else begin
                    nxt = S_EX;
                end
            end
            S_EX: begin
                lvl_en = 1'b1;
                if (is_beq || is_bne) begin
                    pcs_c  = 2'b01;
                    pcwe_c = (is_beq && z) || (is_bne && !z);
                    retire = 1'b1;
                    nxt    = S_IF;
                end else if (is_load || is_store) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                lvl_en = 1'b1;
                req_c  = 1'b1;
                iord_c = 1'b1;
                we_c   = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        retire = 1'b1;
                        nxt    = S_IF;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    trap_bus = 1'b1;
                    nxt      = S_TRAP;
                end
            end
            S_WB: begin
                lvl_en  = 1'b1;
                regwe_c = 1'b1;
                m2r_c   = is_load;
                retire  = 1'b1;
                nxt     = S_IF;
            end
            S_TRAP: begin
                nxt = S_TRAP;
            end
            default: begin
                nxt = S_IF;
            end
        endcase
    end

    // State, watchdog, sticky fault flags and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= S_IF;
            wait_cnt    <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt != cur) begin
                wait_cnt <= '0;
            end else if ((cur == S_IF || cur == S_MEM) && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (retire)   instr_count <= instr_count + CNT_W'(1);
            if (trap_ill) illegal     <= 1'b1;
            if (trap_bus) bus_err     <= 1'b1;
        end
    end

    // Combinational controls drop immediately while reset is asserted.
    assign state    = cur;
    assign mem_req  = !rst && req_c;
    assign mem_we   = !rst && we_c;
    assign iord     = !rst && iord_c;
    assign ir_we    = !rst && irwe_c;
    assign pc_we    = !rst && pcwe_c;
    assign pcsource = rst ? 2'b00 : pcs_c;
    assign reg_we   = !rst && regwe_c;
    assign m2reg    = !rst && m2r_c;
    assign sst      = !rst && lvl_en && dec_legal && (dec_aluc <= 4'd6);
    assign shift    = !rst && lvl_en && dec_legal && (dec_aluc >= 4'd4) && (dec_aluc <= 4'd6);
    assign aluimm   = !rst && lvl_en && dec_legal && (dec_aluc >= 4'd7) && (dec_aluc <= 4'd12);
    assign sext     = !rst && lvl_en && dec_legal &&
                      ((dec_aluc == 4'd7) || (dec_aluc == 4'd11) || (dec_aluc == 4'd12) ||
                       (dec_aluc == 4'd13) || (dec_aluc == 4'd14));
    assign aluc     = (!rst && lvl_en && dec_legal) ? dec_aluc : 4'd0;

endmodule

// File: tb/tb_mccu.sv
// tb_mccu: randomized instruction streams against an instruction-level model
// that expands each instruction class into its expected cycle sequence.
module tb_mccu;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, iord, irwe, pcwe;
        logic [1:0] pcs;
        logic       regwe, m2r, sst, shift, aluimm, sext;
        logic [3:0] aluc;
        logic       ill, berr;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic [11:0] op;
    logic        z, mem_ready;

    logic        mem_req_a, mem_we_a, iord_a, ir_we_a, pc_we_a, reg_we_a, m2reg_a;
    logic        sst_a, shift_a, aluimm_a, sext_a, illegal_a, bus_err_a;
    logic [1:0]  pcsource_a;
    logic [3:0]  aluc_a;
    logic [2:0]  state_a;
    logic [31:0] count_a;

    logic        mem_req_b, mem_we_b, iord_b, ir_we_b, pc_we_b, reg_we_b, m2reg_b;
    logic        sst_b, shift_b, aluimm_b, sext_b, illegal_b, bus_err_b;
    logic [1:0]  pcsource_b;
    logic [3:0]  aluc_b;
    logic [2:0]  state_b;
    logic [31:0] count_b;

    int          checks = 0;
    int          failures = 0;
    int          sel = 0;
    int unsigned cnt_m = 0;
    logic        ill_m = 1'b0;
    logic        berr_m = 1'b0;

    always #5 clk = ~clk;

    mccu #(.TIMEOUT(16), .CNT_W(32), .TRAP_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .op(op), .z(z), .mem_ready(mem_ready),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .iord(iord_a), .ir_we(ir_we_a),
        .pc_we(pc_we_a), .pcsource(pcsource_a), .reg_we(reg_we_a), .m2reg(m2reg_a),
        .sst(sst_a), .shift(shift_a), .aluimm(aluimm_a), .sext(sext_a), .aluc(aluc_a),
        .state(state_a), .illegal(illegal_a), .bus_err(bus_err_a), .instr_count(count_a)
    );

    mccu #(.TIMEOUT(4), .CNT_W(32), .TRAP_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst2), .op(op), .z(z), .mem_ready(mem_ready),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .iord(iord_b), .ir_we(ir_we_b),
        .pc_we(pc_we_b), .pcsource(pcsource_b), .reg_we(reg_we_b), .m2reg(m2reg_b),
        .sst(sst_b), .shift(shift_b), .aluimm(aluimm_b), .sext(sext_b), .aluc(aluc_b),
        .state(state_b), .illegal(illegal_b), .bus_err(bus_err_b), .instr_count(count_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic obs_t observe();
        if (sel == 0)
            return {state_a, mem_req_a, mem_we_a, iord_a, ir_we_a, pc_we_a, pcsource_a,
                    reg_we_a, m2reg_a, sst_a, shift_a, aluimm_a, sext_a, aluc_a,
                    illegal_a, bus_err_a};
        return {state_b, mem_req_b, mem_we_b, iord_b, ir_we_b, pc_we_b, pcsource_b,
                reg_we_b, m2reg_b, sst_b, shift_b, aluimm_b, sext_b, aluc_b,
                illegal_b, bus_err_b};
    endfunction

    function automatic logic [31:0] count_obs();
        return (sel == 0) ? count_a : count_b;
    endfunction

    // Level controls implied by the instruction index (16 = illegal).
    function automatic obs_t lvl(input int idx);
        obs_t e = '0;
        if (idx < 16) begin
            e.aluc   = 4'(idx);
            e.sst    = (idx <= 6);
            e.shift  = (idx >= 4 && idx <= 6);
            e.aluimm = (idx >= 7 && idx <= 12);
            e.sext   = (idx == 7 || idx == 11 || idx == 12 || idx == 13 || idx == 14);
        end
        return e;
    endfunction

    function automatic logic [11:0] enc(input int idx);
        logic [5:0] r = 6'($urandom);
        case (idx)
            0:  return 12'b000000_000001;
            1:  return 12'b000001_000001;
            2:  return 12'b000001_000010;
            3:  return 12'b000001_000100;
            4:  return 12'b000010_000001;
            5:  return 12'b000010_000010;
            6:  return 12'b000010_000011;
            7:  return {6'b000101, r};
            8:  return {6'b001001, r};
            9:  return {6'b001010, r};
            10: return {6'b001100, r};
            11: return {6'b001101, r};
            12: return {6'b001110, r};
            13: return {6'b001111, r};
            14: return {6'b010000, r};
            15: return {6'b010010, r};
            default: begin
                case ($urandom_range(0, 4))
                    0: return {6'b000011, r};
                    1: return 12'b000000_000010;
                    2: return {6'b111111, r};
                    3: return 12'b000001_000011;
                    default: return 12'b000010_000000;
                endcase
            end
        endcase
    endfunction

    // One clock cycle: drive mem_ready, compare at the falling edge.
    task automatic cyc(input obs_t e, input logic rdy, input string tag);
        mem_ready = rdy;
        e.ill  = ill_m;
        e.berr = berr_m;
        @(negedge clk);
        check(tag, 64'(observe()), 64'(e));
        check({tag, "_cnt"}, 64'(count_obs()), 64'(cnt_m));
        @(posedge clk);
        #1;
    endtask

    task automatic trap_cycles(input int n);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.st = 3'd7;
            cyc(e, 1'($urandom), "trap");
        end
    endtask

    task automatic do_reset();
        obs_t e = '0;
        if (sel == 0) rst = 1'b1; else rst2 = 1'b1;
        cnt_m  = 0;
        ill_m  = 1'b0;
        berr_m = 1'b0;
        cyc(e, 1'b1, "reset");
        if (sel == 0) rst = 1'b0; else rst2 = 1'b0;
    endtask

    // Expected cycle sequence for one instruction given its class and wait counts.
    task automatic run_instr(input int idx, input logic zv, input int ifw, input int memw);
        obs_t e, l;
        int   tmo = (sel == 0) ? 16 : 4;
        logic trap_en = (sel == 0);
        op = enc(idx);
        z  = zv;
        l  = lvl(idx);
        for (int i = 0; i < ifw && i < tmo; i++) begin
            e = '0; e.req = 1'b1;
            cyc(e, 1'b0, "if_wait");
        end
        if (ifw >= tmo) begin
            berr_m = 1'b1;
            trap_cycles(3);
            return;
        end
        e = '0; e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1;
        cyc(e, 1'b1, "if");
        e = l; e.st = 3'd1;
        if (idx == 15) begin
            e.pcwe = 1'b1; e.pcs = 2'b11;
            cyc(e, 1'($urandom), "id_jump");
            cnt_m++;
            return;
        end
        if (idx == 16) begin
            cyc(e, 1'($urandom), "id_illegal");
            if (trap_en) begin
                ill_m = 1'b1;
                trap_cycles(3);
            end else begin
                cnt_m++;
            end
            return;
        end
        cyc(e, 1'($urandom), "id");
        e = l; e.st = 3'd2;
        if (idx == 13 || idx == 14) begin
            e.pcs  = 2'b01;
            e.pcwe = (idx == 13) ? zv : !zv;
            cyc(e, 1'($urandom), "ex_branch");
            cnt_m++;
            return;
        end
        cyc(e, 1'($urandom), "ex");
        if (idx == 11 || idx == 12) begin
            e = l; e.st = 3'd3; e.req = 1'b1; e.iord = 1'b1; e.we = (idx == 12);
            for (int i = 0; i < memw && i < tmo; i++) cyc(e, 1'b0, "mem_wait");
            if (memw >= tmo) begin
                berr_m = 1'b1;
                trap_cycles(3);
                return;
            end
            cyc(e, 1'b1, "mem");
            if (idx == 12) begin
                cnt_m++;
                return;
            end
        end
        e = l; e.st = 3'd4; e.regwe = 1'b1; e.m2r = (idx == 11);
        cyc(e, 1'($urandom), "wb");
        cnt_m++;
    endtask

    initial begin
        obs_t e;
        rst = 1'b1; rst2 = 1'b1; op = '0; z = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // TRAP_EN=1, TIMEOUT=16 instance
        sel = 0;
        do_reset();
        run_instr(0, 1'b0, 0, 0);
        run_instr(11, 1'b0, 0, 3);
        run_instr(13, 1'b1, 0, 0);
        run_instr(13, 1'b0, 0, 0);
        run_instr(14, 1'b0, 0, 0);
        run_instr(15, 1'b0, 0, 0);
        run_instr(12, 1'b0, 1, 2);
        run_instr(16, 1'b0, 0, 0);
        do_reset();
        run_instr(0, 1'b0, 16, 0);
        do_reset();
        run_instr(0, 1'b0, 15, 0);
        run_instr(11, 1'b0, 0, 16);
        do_reset();
        for (int n = 0; n < 80; n++) begin
            run_instr($urandom_range(0, 16), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3));
            if (ill_m || berr_m) do_reset();
        end

        // Reset asserted mid store: memory strobes must drop without a clock edge.
        run_instr(1, 1'b0, 0, 0);
        op = enc(12);
        e = '0; e.req = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1;
        cyc(e, 1'b1, "st_if");
        e = lvl(12); e.st = 3'd1;
        cyc(e, 1'b1, "st_id");
        e.st = 3'd2;
        cyc(e, 1'b1, "st_ex");
        e.st = 3'd3; e.req = 1'b1; e.iord = 1'b1; e.we = 1'b1;
        cyc(e, 1'b0, "st_mem");
        mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("abort_strobes", 64'({mem_req_a, mem_we_a}), 64'(0));
        check("abort_state", 64'(state_a), 64'(0));
        do_reset();
        run_instr(0, 1'b0, 0, 0);

        // TRAP_EN=0, TIMEOUT=4 instance
        rst = 1'b1;
        sel = 1;
        do_reset();
        run_instr(16, 1'b0, 0, 0);
        run_instr(0, 1'b0, 3, 0);
        run_instr(12, 1'b0, 0, 3);
        run_instr(11, 1'b0, 0, 4);
        do_reset();
        for (int n = 0; n < 60; n++) begin
            run_instr($urandom_range(0, 16), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 4));
            if (ill_m || berr_m) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
